boot_copy_engine: RTL and testbench
===================================

BOOT_COPY_ENGINE -- requirements
Module: boot_copy_engine

Interface
REQ-001 Parameter ADDR_W, default 16, address width of source and destination buses.
REQ-002 Parameter DATA_W, default 8, data word width.
REQ-003 Parameter LEN, default 276, words copied per run; legal range 1..2^ADDR_W.
REQ-004 Parameter RD_LAT, default 1, source read latency in cycles; legal range 1..7.
REQ-005 Parameter DEST_BASE, default 0, first destination address.
REQ-006 Parameter EXEC_ADDR, default 0, value presented on exec_addr.
REQ-007 clk_sys  in  1  sole clock; all state updates on its rising edge.
REQ-008 reset  in  1  asynchronous, active-high reset.
REQ-009 start  in  1  level sampled each cycle; when high, begins (or restarts) a copy run.
REQ-010 src_addr  out  ADDR_W  source word address.
REQ-011 src_data  in  DATA_W  source word, valid RD_LAT cycles after src_addr changes.
REQ-012 dst_addr  out  ADDR_W  destination address.
REQ-013 dst_data  out  DATA_W  destination write data.
REQ-014 dst_wr  out  1  destination write strobe.
REQ-015 dst_wait  in  1  destination stall; write accepted only in a cycle with dst_wr=1 and dst_wait=0.
REQ-016 busy  out  1  high while a run is in progress.
REQ-017 done  out  1  one-cycle pulse at end of run; qualifies exec_addr.
REQ-018 exec_addr  out  ADDR_W  constant EXEC_ADDR.
REQ-019 checksum  out  16  modulo-2^16 sum of all words accepted in the current or last run, zero-extended.

Function
REQ-020 States: IDLE, FETCH, WRITE, NEXT, DONE.
REQ-021 IDLE: start=1 -> src_addr=0, dst_addr=DEST_BASE, checksum=0, fetch counter=RD_LAT, busy=1 -> FETCH.
REQ-022 FETCH: counter decrements once per cycle; on the edge where it reaches 0, dst_data latches src_data -> WRITE.
REQ-023 WRITE: dst_wr=1; dst_wait=1 -> hold dst_wr, dst_addr, dst_data stable; dst_wait=0 -> accept, checksum += dst_data -> NEXT.
REQ-024 NEXT: dst_wr=0; word index = LEN-1 -> DONE; otherwise src_addr+1, dst_addr+1, counter reloaded to RD_LAT -> FETCH.
REQ-025 DONE: done=1 and busy=0 for exactly one cycle -> IDLE; done is never high in any other state.
REQ-026 Address arithmetic is modulo 2^ADDR_W; dst_addr wraps from all-ones to 0 without error.
REQ-027 Per word with no stall: RD_LAT+2 cycles; done is high in the cycle after edge LEN*(RD_LAT+2), counting the start-sampling edge as 0.
REQ-028 Each stall cycle adds exactly one cycle to the run; no word is skipped or duplicated.
REQ-029 start=1 in any non-IDLE state aborts the current run and re-enters FETCH with the REQ-021 initial values on the next edge; no done pulse is issued for the aborted run.
REQ-030 start held high continuously restarts every cycle; the run proceeds only after start falls.
REQ-031 dst_wr is low in every state except WRITE.

Reset
REQ-032 reset=1 forces IDLE immediately, without waiting for a clock edge.
REQ-033 Reset values: src_addr=0, dst_addr=DEST_BASE, dst_data=0, dst_wr=0, busy=0, done=0, checksum=0.
REQ-034 Reset asserted mid-run abandons the run; no further dst_wr pulse and no done pulse.
REQ-035 After reset deasserts, the block stays in IDLE until start is sampled high.

Verification
REQ-036 LEN=4, RD_LAT=1, source words 0x11,0x22,0x33,0x44, no stall -> writes to addresses 0..3 at 3-cycle spacing; done in the cycle after edge 12; checksum=0x00AA.
REQ-037 RD_LAT=3, dst_wait high 5 cycles on word 2 -> dst_wr/addr/data held for 5 cycles; done delayed by exactly 5 cycles; data intact.
REQ-038 DEST_BASE=0xFFFE, LEN=4 -> destination addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-039 start pulsed again after word 2 -> run restarts at src_addr=0 and checksum=0; only one done pulse, at the end of the restarted run.
REQ-040 reset asserted asynchronously mid-WRITE -> dst_wr and busy drop before the next edge; no done pulse; a subsequent start performs a full run.

Source files
------------

// File: rtl/boot_copy_engine.sv
// boot_copy_engine: copies LEN words from a fixed-latency source memory
// to a stallable destination port starting at DEST_BASE. It accumulates a
// 16-bit checksum of the accepted words and pulses done together with
// exec_addr when the copy completes.
module boot_copy_engine #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int LEN       = 276,
  parameter int RD_LAT    = 1,
  parameter int DEST_BASE = 0,
  parameter int EXEC_ADDR = 0
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [DATA_W-1:0] src_data,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [DATA_W-1:0] dst_data,
  output logic              dst_wr,
  input  logic              dst_wait,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] exec_addr,
  output logic [15:0]       checksum
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WRITE,
    ST_NEXT,
    ST_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LP_DEST_BASE = ADDR_W'(DEST_BASE);
  localparam logic [ADDR_W-1:0] LP_LAST_IDX  = ADDR_W'(LEN - 1);
  localparam logic [ADDR_W-1:0] LP_EXEC_ADDR = ADDR_W'(EXEC_ADDR);
  localparam logic [2:0]        LP_RD_LAT    = 3'(RD_LAT);

  state_t            r_state;
  logic [ADDR_W-1:0] r_src_addr;
  logic [ADDR_W-1:0] r_dst_addr;
  logic [DATA_W-1:0] r_dst_data;
  logic              r_dst_wr;
  logic              r_busy;
  logic              r_done;
  logic [15:0]       r_checksum;
  logic [2:0]        r_fetch_cnt;
  logic [ADDR_W-1:0] r_word_idx;

  // Running checksum including the word currently offered on dst_data.
  logic [15:0]       w_sum;
  assign w_sum = r_checksum + 16'(r_dst_data);

  // Copy sequencer: start has priority in every state and (re)initialises the run.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_src_addr  <= '0;
      r_dst_addr  <= LP_DEST_BASE;
      r_dst_data  <= '0;
      r_dst_wr    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_checksum  <= '0;
      r_fetch_cnt <= '0;
      r_word_idx  <= '0;
    end else if (start) begin
      r_state     <= ST_FETCH;
      r_src_addr  <= '0;
      r_dst_addr  <= LP_DEST_BASE;
      r_dst_wr    <= 1'b0;
      r_busy      <= 1'b1;
      r_done      <= 1'b0;
      r_checksum  <= '0;
      r_fetch_cnt <= LP_RD_LAT;
      r_word_idx  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
        end
        ST_FETCH: begin
          r_fetch_cnt <= r_fetch_cnt - 3'd1;
          // Source word becomes valid on the edge where the counter hits zero.
          if (r_fetch_cnt == 3'd1) begin
            r_dst_data <= src_data;
            r_dst_wr   <= 1'b1;
            r_state    <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          // While stalled, address, data and strobe simply hold.
          if (!dst_wait) begin
            r_dst_wr   <= 1'b0;
            r_checksum <= w_sum;
            r_state    <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (r_word_idx == LP_LAST_IDX) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_src_addr  <= r_src_addr + ADDR_W'(1);
            r_dst_addr  <= r_dst_addr + ADDR_W'(1);
            r_word_idx  <= r_word_idx + ADDR_W'(1);
            r_fetch_cnt <= LP_RD_LAT;
            r_state     <= ST_FETCH;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_dst_wr <= 1'b0;
          r_busy   <= 1'b0;
          r_done   <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign src_addr  = r_src_addr;
  assign dst_addr  = r_dst_addr;
  assign dst_data  = r_dst_data;
  assign dst_wr    = r_dst_wr;
  assign busy      = r_busy;
  assign done      = r_done;
  assign checksum  = r_checksum;
  assign exec_addr = LP_EXEC_ADDR;

endmodule

// File: tb/tb_boot_copy_engine.sv
// Directed bench for boot_copy_engine. Instance A: LEN=4, RD_LAT=1, base 0.
// Instance B: LEN=4, RD_LAT=3, base 0xFFFE (wraps), optional 5-cycle stall on word 2.
module tb_boot_copy_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  // Instance A signals
  logic [15:0] src_addr_a, dst_addr_a, exec_addr_a, checksum_a;
  logic [7:0]  src_data_a, dst_data_a;
  logic        dst_wr_a, busy_a, done_a;
  logic        dst_wait_a = 1'b0;

  // Instance B signals
  logic [15:0] src_addr_b, dst_addr_b, exec_addr_b, checksum_b;
  logic [7:0]  src_data_b, dst_data_b;
  logic        dst_wr_b, busy_b, done_b, dst_wait_b;
  logic [7:0]  pipe_b [2];
  logic        stall_en_b = 1'b0;
  int          stall_cnt_b = 0;
  int          stall_base_b = 0;

  // Monitor records
  int          acc_a = 0, acc_b = 0;
  logic [15:0] acc_addr_a [64];
  logic [15:0] acc_addr_b [64];
  logic [7:0]  acc_data_a [64];
  logic [7:0]  acc_data_b [64];
  int          acc_cyc_a [64];
  int          acc_cyc_b [64];
  int          wr_cyc_a = 0, wr_cyc_b = 0;
  int          done_cnt_a = 0, done_cnt_b = 0;
  int          done_cyc_a = 0, done_cyc_b = 0;
  int          stall_seen_b = 0, stall_bad_b = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [7:0] mem_a(input logic [15:0] a);
    case (a)
      16'd0:   return 8'h11;
      16'd1:   return 8'h22;
      16'd2:   return 8'h33;
      16'd3:   return 8'h44;
      default: return 8'hEE;
    endcase
  endfunction

  function automatic logic [7:0] mem_b(input logic [15:0] a);
    case (a)
      16'd0:   return 8'hA5;
      16'd1:   return 8'h5A;
      16'd2:   return 8'hFF;
      16'd3:   return 8'h01;
      default: return 8'hEE;
    endcase
  endfunction

  // Source for A: latency 1 means data follows the address within the cycle.
  assign src_data_a = mem_a(src_addr_a);

  // Source for B: latency 3 = combinational lookup plus two register stages.
  always @(posedge clk) begin
    pipe_b[0] <= mem_b(src_addr_b);
    pipe_b[1] <= pipe_b[0];
  end
  assign src_data_b = pipe_b[1];

  // Destination B stalls exactly 5 cycles on the word written to 0x0000 (word 2).
  assign dst_wait_b = stall_en_b && dst_wr_b && (dst_addr_b == 16'h0000) &&
                      ((stall_cnt_b - stall_base_b) < 5);
  always @(posedge clk) if (dst_wait_b) stall_cnt_b++;

  boot_copy_engine #(
    .ADDR_W(16), .DATA_W(8), .LEN(4), .RD_LAT(1), .DEST_BASE(0), .EXEC_ADDR(16'h0100)
  ) u_dut_a (
    .clk_sys(clk), .reset(rst), .start(start),
    .src_addr(src_addr_a), .src_data(src_data_a),
    .dst_addr(dst_addr_a), .dst_data(dst_data_a), .dst_wr(dst_wr_a), .dst_wait(dst_wait_a),
    .busy(busy_a), .done(done_a), .exec_addr(exec_addr_a), .checksum(checksum_a)
  );

  boot_copy_engine #(
    .ADDR_W(16), .DATA_W(8), .LEN(4), .RD_LAT(3), .DEST_BASE(16'hFFFE), .EXEC_ADDR(16'hBEEF)
  ) u_dut_b (
    .clk_sys(clk), .reset(rst), .start(start),
    .src_addr(src_addr_b), .src_data(src_data_b),
    .dst_addr(dst_addr_b), .dst_data(dst_data_b), .dst_wr(dst_wr_b), .dst_wait(dst_wait_b),
    .busy(busy_b), .done(done_b), .exec_addr(exec_addr_b), .checksum(checksum_b)
  );

  // Negedge monitor: logs accepted writes, strobe cycles, done pulses and stall behaviour.
  always @(negedge clk) begin
    if (dst_wr_a) begin
      wr_cyc_a++;
      if (!dst_wait_a && acc_a < 64) begin
        acc_addr_a[acc_a] = dst_addr_a;
        acc_data_a[acc_a] = dst_data_a;
        acc_cyc_a[acc_a]  = cyc;
        acc_a++;
      end
    end
    if (dst_wr_b) begin
      wr_cyc_b++;
      if (!dst_wait_b && acc_b < 64) begin
        acc_addr_b[acc_b] = dst_addr_b;
        acc_data_b[acc_b] = dst_data_b;
        acc_cyc_b[acc_b]  = cyc;
        acc_b++;
      end else if (dst_wait_b) begin
        stall_seen_b++;
        if (dst_addr_b !== 16'h0000 || dst_data_b !== 8'hFF) stall_bad_b++;
      end
    end
    if (done_a) begin
      done_cnt_a++;
      done_cyc_a = cyc;
    end
    if (done_b) begin
      done_cnt_b++;
      done_cyc_b = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives one start pulse from posedge+1; returns the index of the sampling edge.
  task automatic start_run(output int c0);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    c0 = cyc;
  endtask

  // Four writes to 0..3, data 11/22/33/44, one every 3 cycles.
  task automatic check_run_a(input int base, input int c0, input string tag);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s_a_addr%0d", tag, k), 32'(acc_addr_a[base + k]), 32'(k));
      check($sformatf("%s_a_data%0d", tag, k), 32'(acc_data_a[base + k]), 32'(mem_a(16'(k))));
      check($sformatf("%s_a_cyc%0d", tag, k), 32'(acc_cyc_a[base + k]), 32'(c0 + 3 * k + 1));
    end
  endtask

  // Four writes to FFFE,FFFF,0000,0001, one every 5 cycles, plus stall on word 2.
  task automatic check_run_b(input int base, input int c0, input int stall, input string tag);
    logic [15:0] ea;
    for (int k = 0; k < 4; k++) begin
      ea = 16'hFFFE + 16'(k);
      check($sformatf("%s_b_addr%0d", tag, k), 32'(acc_addr_b[base + k]), 32'(ea));
      check($sformatf("%s_b_data%0d", tag, k), 32'(acc_data_b[base + k]), 32'(mem_b(16'(k))));
      check($sformatf("%s_b_cyc%0d", tag, k), 32'(acc_cyc_b[base + k]),
            32'(c0 + 5 * k + 3 + ((k >= 2) ? stall : 0)));
    end
  endtask

  initial begin
    int c0, c1;
    int ba, bb, bda, bdb, bwa, bwb, bsb;

    rst   = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_src_a",  32'(src_addr_a), 32'h0);
    check("rst_dst_a",  32'(dst_addr_a), 32'h0);
    check("rst_dst_b",  32'(dst_addr_b), 32'hFFFE);
    check("rst_data_a", 32'(dst_data_a), 32'h0);
    check("rst_wr_a",   32'(dst_wr_a),   32'h0);
    check("rst_busy_a", 32'(busy_a),     32'h0);
    check("rst_done_b", 32'(done_b),     32'h0);
    check("rst_csum_a", 32'(checksum_a), 32'h0);
    check("exec_a",     32'(exec_addr_a), 32'h0100);
    check("exec_b",     32'(exec_addr_b), 32'hBEEF);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_busy_a", 32'(busy_a), 32'h0);
    check("idle_busy_b", 32'(busy_b), 32'h0);
    check("idle_wr",     32'(wr_cyc_a + wr_cyc_b), 32'h0);

    // Plain run on both instances.
    ba = acc_a; bb = acc_b; bda = done_cnt_a; bdb = done_cnt_b; bwa = wr_cyc_a; bwb = wr_cyc_b;
    start_run(c0);
    check("run_busy_a", 32'(busy_a), 32'h1);
    check("run_busy_b", 32'(busy_b), 32'h1);
    repeat (30) @(posedge clk);
    #1;
    check("run_nacc_a",  32'(acc_a - ba), 32'd4);
    check("run_nacc_b",  32'(acc_b - bb), 32'd4);
    check_run_a(ba, c0, "run");
    check_run_b(bb, c0, 0, "run");
    check("run_ndone_a", 32'(done_cnt_a - bda), 32'd1);
    check("run_ndone_b", 32'(done_cnt_b - bdb), 32'd1);
    check("run_tdone_a", 32'(done_cyc_a), 32'(c0 + 12));
    check("run_tdone_b", 32'(done_cyc_b), 32'(c0 + 20));
    check("run_nwr_a",   32'(wr_cyc_a - bwa), 32'd4);
    check("run_nwr_b",   32'(wr_cyc_b - bwb), 32'd4);
    check("run_csum_a",  32'(checksum_a), 32'h00AA);
    check("run_csum_b",  32'(checksum_b), 32'h01FF);
    check("run_end_busy", 32'({busy_a, busy_b, done_a, done_b}), 32'h0);

    // Stall of 5 cycles on word 2 of instance B.
    ba = acc_a; bb = acc_b; bda = done_cnt_a; bdb = done_cnt_b; bwb = wr_cyc_b; bsb = stall_seen_b;
    stall_base_b = stall_cnt_b;
    stall_en_b   = 1'b1;
    start_run(c0);
    repeat (35) @(posedge clk);
    #1;
    stall_en_b = 1'b0;
    check("stl_nacc_b",  32'(acc_b - bb), 32'd4);
    check_run_b(bb, c0, 5, "stl");
    check_run_a(ba, c0, "stl");
    check("stl_seen_b",  32'(stall_seen_b - bsb), 32'd5);
    check("stl_hold_b",  32'(stall_bad_b), 32'd0);
    check("stl_nwr_b",   32'(wr_cyc_b - bwb), 32'd9);
    check("stl_tdone_b", 32'(done_cyc_b), 32'(c0 + 25));
    check("stl_ndone_b", 32'(done_cnt_b - bdb), 32'd1);
    check("stl_tdone_a", 32'(done_cyc_a), 32'(c0 + 12));
    check("stl_csum_b",  32'(checksum_b), 32'h01FF);

    // Restart after two words of A have been accepted.
    bda = done_cnt_a; bdb = done_cnt_b;
    start_run(c0);
    repeat (6) @(posedge clk);
    #1;
    check("rs_mid_csum_a", 32'(checksum_a), 32'h0033);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    c1 = cyc;
    check("rs_csum_a", 32'(checksum_a), 32'h0);
    check("rs_csum_b", 32'(checksum_b), 32'h0);
    check("rs_src_a",  32'(src_addr_a), 32'h0);
    check("rs_busy_a", 32'(busy_a), 32'h1);
    ba = acc_a; bb = acc_b;
    repeat (30) @(posedge clk);
    #1;
    check("rs_nacc_a",  32'(acc_a - ba), 32'd4);
    check_run_a(ba, c1, "rs");
    check_run_b(bb, c1, 0, "rs");
    check("rs_ndone_a", 32'(done_cnt_a - bda), 32'd1);
    check("rs_ndone_b", 32'(done_cnt_b - bdb), 32'd1);
    check("rs_tdone_a", 32'(done_cyc_a), 32'(c1 + 12));
    check("rs_tdone_b", 32'(done_cyc_b), 32'(c1 + 20));
    check("rs_csum_a2", 32'(checksum_a), 32'h00AA);

    // Asynchronous reset while A is in WRITE.
    bda = done_cnt_a; bdb = done_cnt_b;
    start_run(c0);
    @(posedge clk);
    #1;
    check("ar_pre_wr_a", 32'(dst_wr_a), 32'h1);
    #1;
    rst = 1'b1;
    #1;
    check("ar_wr_a",   32'(dst_wr_a), 32'h0);
    check("ar_busy_a", 32'(busy_a),   32'h0);
    check("ar_busy_b", 32'(busy_b),   32'h0);
    bwa = wr_cyc_a; bwb = wr_cyc_b;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("ar_nwr",    32'((wr_cyc_a - bwa) + (wr_cyc_b - bwb)), 32'd0);
    check("ar_ndone",  32'((done_cnt_a - bda) + (done_cnt_b - bdb)), 32'd0);
    check("ar_idle_a", 32'(busy_a), 32'h0);
    ba = acc_a; bb = acc_b;
    start_run(c0);
    repeat (30) @(posedge clk);
    #1;
    check("ar_nacc_a", 32'(acc_a - ba), 32'd4);
    check("ar_nacc_b", 32'(acc_b - bb), 32'd4);
    check_run_a(ba, c0, "ar");
    check_run_b(bb, c0, 0, "ar");
    check("ar_tdone_a", 32'(done_cyc_a), 32'(c0 + 12));
    check("ar_tdone_b", 32'(done_cyc_b), 32'(c0 + 20));
    check("ar_csum_a",  32'(checksum_a), 32'h00AA);
    check("ar_csum_b",  32'(checksum_b), 32'h01FF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
